// File: rtl/noise_pkg.sv
// -----------------------------------------------------------------------------
// noise_pkg
// Shared definitions for the central-limit-theorem noise generator:
//   - state_t   : generator FSM states (IDLE, FILL, SCALE, OUT)
//   - LANE_W    : width of one uniform lane taken from a 64-bit URNG word
//   - acc_width : accumulator width needed to sum 4*words signed lane terms
// -----------------------------------------------------------------------------
package noise_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_SCALE = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  localparam int LANE_W = 16;

  // One sign bit plus enough headroom for 4*words lane terms of LANE_W bits.
  function automatic int acc_width(input int words);
    return LANE_W + $clog2(4 * words) + 1;
  endfunction

endpackage

// File: rtl/clt_lane_sum.sv
// -----------------------------------------------------------------------------
// clt_lane_sum
// Combinational sum of the four signed 16-bit lane terms carried by one URNG
// word. Result is 18 bits, enough for 4 * (-32768) without overflow.
// Ports:
//   i_terms : four packed signed lane terms, lane 0 in bits [15:0]
//   o_sum   : signed sum of the four terms
// -----------------------------------------------------------------------------
module clt_lane_sum
  import noise_pkg::*;
(
  input  logic        [4*LANE_W-1:0] i_terms,
  output logic signed [LANE_W+1:0]   o_sum
);

  logic signed [LANE_W+1:0] w_ext [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ext
      assign w_ext[gi] = {{2{i_terms[gi*LANE_W+LANE_W-1]}}, i_terms[gi*LANE_W +: LANE_W]};
    end
  endgenerate

  assign o_sum = w_ext[0] + w_ext[1] + w_ext[2] + w_ext[3];

endmodule

// File: rtl/clt_noise_gen.sv
// -----------------------------------------------------------------------------
// clt_noise_gen
// Approximately Gaussian noise by summing 4*WORDS uniform 16-bit lanes
// (central limit theorem), scaled by an unsigned Q0.16 sigma multiplier.
// Build option: define CLT_NOISE_SAT_EN to saturate the scaled result to the
// OUT_W signed range; otherwise the low OUT_W bits are kept (wrap).
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   start         : level enable, samples produced back-to-back while high
//   scale         : Q0.16 sigma multiplier, latched when a sample begins
//   urng_en       : request one 64-bit word from the upstream URNG
//   urng_valid    : upstream word valid (one cycle after its request)
//   urng_data     : upstream uniform word
//   noise_valid   : noise_out holds a sample
//   noise_ready   : downstream accept
//   noise_out     : signed noise sample
//   busy          : FSM not idle
//   proto_err     : sticky, set by a urng_valid with no outstanding request
// -----------------------------------------------------------------------------
module clt_noise_gen
  import noise_pkg::*;
#(
  parameter int WORDS = 2,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      scale,
  output logic             urng_en,
  input  logic             urng_valid,
  input  logic [63:0]      urng_data,
  output logic             noise_valid,
  input  logic             noise_ready,
  output logic [OUT_W-1:0] noise_out,
  output logic             busy,
  output logic             proto_err
);

  localparam int ACC_W  = acc_width(WORDS);
  localparam int PROD_W = ACC_W + 17;
  localparam int CNT_W  = $clog2(WORDS + 1);
  localparam logic [CNT_W-1:0] WORDS_C = CNT_W'(WORDS);

  state_t                     r_state;
  state_t                     w_state_next;
  logic [CNT_W-1:0]           r_iss;
  logic [CNT_W-1:0]           r_rcv;
  logic signed [ACC_W-1:0]    r_acc;
  logic [15:0]                r_scale;
  logic [OUT_W-1:0]           r_noise_out;
  logic                       r_proto_err;

  logic                       w_start_sample;
  logic                       w_accept;
  logic [63:0]                w_terms;
  logic signed [LANE_W+1:0]   w_lane_sum;
  logic signed [PROD_W-1:0]   w_acc_x;
  logic signed [PROD_W-1:0]   w_scale_x;
  logic signed [PROD_W-1:0]   w_prod;
  logic signed [PROD_W-1:0]   w_shift;
  logic [OUT_W-1:0]           w_scaled;
  logic                       w_unused;

  // Lane term u - 32768 is just u with its MSB inverted.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_terms[gi*LANE_W +: LANE_W] =
        {~urng_data[gi*LANE_W+LANE_W-1], urng_data[gi*LANE_W +: LANE_W-1]};
    end
  endgenerate

  clt_lane_sum u_lane_sum (
    .i_terms (w_terms),
    .o_sum   (w_lane_sum)
  );

  // A word is only taken while a request is outstanding; anything else is a
  // protocol violation and is dropped.
  assign w_accept = urng_valid && (r_state == ST_FILL) && (r_rcv < r_iss);

  // Scale: both operands widened to the full product width so the multiply
  // is exact; the arithmetic shift removes the Q0.16 fraction.
  assign w_acc_x   = PROD_W'(r_acc);
  assign w_scale_x = PROD_W'($signed({1'b0, r_scale}));
  assign w_prod    = w_acc_x * w_scale_x;
  assign w_shift   = w_prod >>> 16;

  always_comb begin
    w_scaled = w_shift[OUT_W-1:0];
`ifdef CLT_NOISE_SAT_EN
    // In range only if every bit above the OUT_W sign bit matches it.
    if (!((&w_shift[PROD_W-1:OUT_W-1]) || !(|w_shift[PROD_W-1:OUT_W-1]))) begin
      w_scaled = w_shift[PROD_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                   : {1'b0, {(OUT_W-1){1'b1}}};
    end
`endif
  end

  assign w_unused = ^{w_prod, w_shift};

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    urng_en        = 1'b0;
    noise_valid    = 1'b0;
    w_start_sample = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next   = ST_FILL;
          w_start_sample = 1'b1;
        end
      end
      ST_FILL: begin
        urng_en = (r_iss < WORDS_C);
        if (w_accept && (r_rcv == WORDS_C - 1'b1)) begin
          w_state_next = ST_SCALE;
        end
      end
      ST_SCALE: begin
        w_state_next = ST_OUT;
      end
      ST_OUT: begin
        noise_valid = 1'b1;
        if (noise_ready) begin
          if (start) begin
            w_state_next   = ST_FILL;
            w_start_sample = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iss       <= '0;
      r_rcv       <= '0;
      r_acc       <= '0;
      r_scale     <= '0;
      r_noise_out <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_start_sample) begin
        r_scale <= scale;
        r_acc   <= '0;
        r_iss   <= '0;
        r_rcv   <= '0;
      end else begin
        if (urng_en) begin
          r_iss <= r_iss + 1'b1;
        end
        if (w_accept) begin
          r_acc <= r_acc + {{(ACC_W-LANE_W-2){w_lane_sum[LANE_W+1]}}, w_lane_sum};
          r_rcv <= r_rcv + 1'b1;
        end
      end
      if (urng_valid && !w_accept) begin
        r_proto_err <= 1'b1;
      end
      if (r_state == ST_SCALE) begin
        r_noise_out <= w_scaled;
      end
    end
  end

  assign noise_out = r_noise_out;
  assign busy      = (r_state != ST_IDLE);
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_clt_noise_gen.sv
// -----------------------------------------------------------------------------
// tb_clt_noise_gen
// Self-checking bench for clt_noise_gen (WORDS=2, OUT_W=16). An upstream URNG
// is emulated inside the per-cycle tick task; every delivered word is queued
// and the expected sample is recomputed from plain integer arithmetic:
// sum of (lane - 32768), times scale, floor-divided by 65536, then wrapped or
// saturated (CLT_NOISE_SAT_EN) to 16 bits.
// -----------------------------------------------------------------------------
module tb_clt_noise_gen;

  localparam int WORDS = 2;
  localparam int OUT_W = 16;

`ifdef CLT_NOISE_SAT_EN
  localparam logic [15:0] EXP_MAX = 16'h7FFF;
`else
  localparam logic [15:0] EXP_MAX = 16'hFFFC;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [15:0]      scale = '0;
  logic             urng_en;
  logic             urng_valid = 1'b0;
  logic [63:0]      urng_data = '0;
  logic             noise_valid;
  logic             noise_ready = 1'b0;
  logic [OUT_W-1:0] noise_out;
  logic             busy;
  logic             proto_err;

  int          total = 0;
  int          bad = 0;
  bit          auto_urng = 1'b1;
  bit          fixed_mode = 1'b0;
  logic [63:0] fixed_word = '0;
  logic [63:0] words_q[$];
  int          en_cnt = 0;
  logic [15:0] last_out = '0;

  clt_noise_gen #(.WORDS(WORDS), .OUT_W(OUT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .scale       (scale),
    .urng_en     (urng_en),
    .urng_valid  (urng_valid),
    .urng_data   (urng_data),
    .noise_valid (noise_valid),
    .noise_ready (noise_ready),
    .noise_out   (noise_out),
    .busy        (busy),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; the emulated URNG answers a request seen this cycle with a
  // word valid during the next cycle.
  task automatic tick();
    logic en;
    en = urng_en;
    if (en === 1'b1) en_cnt++;
    @(posedge clk);
    #1;
    if (auto_urng) begin
      urng_valid = (en === 1'b1);
      if (en === 1'b1) begin
        urng_data = fixed_mode ? fixed_word : {$urandom, $urandom};
        words_q.push_back(urng_data);
      end else begin
        urng_data = '0;
      end
    end
  endtask

  function automatic logic [15:0] model(input logic [63:0] ws [WORDS], input logic [15:0] sc);
    longint acc;
    longint sh;
    acc = 0;
    for (int k = 0; k < WORDS; k++) begin
      for (int l = 0; l < 4; l++) begin
        acc += longint'(ws[k][16*l +: 16]) - 32768;
      end
    end
    sh = (acc * longint'(sc)) >>> 16;
`ifdef CLT_NOISE_SAT_EN
    if (sh > 32767) sh = 32767;
    else if (sh < -32768) sh = -32768;
`endif
    return sh[15:0];
  endfunction

  // Called in the first FILL cycle of a sample (first urng_en cycle).
  task automatic finish_sample(input string tag, input logic [15:0] sc, input int hold,
                               input bit keep, input logic [15:0] next_sc);
    int lat;
    logic [63:0] ws [WORDS];
    logic [15:0] exp;
    en_cnt = 0;
    lat = 0;
    while (noise_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, WORDS + 2);
    chk({tag, "_en_count"}, en_cnt, WORDS);
    if (words_q.size() < WORDS) begin
      chk({tag, "_words_delivered"}, words_q.size(), WORDS);
      exp = 'x;
    end else begin
      for (int k = 0; k < WORDS; k++) ws[k] = words_q.pop_front();
      exp = model(ws, sc);
    end
    last_out = noise_out;
    chk({tag, "_noise_out"}, noise_out, exp);
    $display("sample %s scale=%04h noise_out=%04h expected=%04h latency=%0d", tag, sc, noise_out, exp, lat);
    for (int h = 0; h < hold; h++) begin
      noise_ready = 1'b0;
      tick();
      chk({tag, "_hold_out"}, noise_out, exp);
      chk({tag, "_hold_en"}, urng_en, 1'b0);
      chk({tag, "_hold_valid"}, noise_valid, 1'b1);
    end
    noise_ready = 1'b1;
    start = keep;
    scale = next_sc;
    tick();
    noise_ready = 1'b0;
    scale = 16'($urandom);
    if (!keep) begin
      chk({tag, "_idle_busy"}, busy, 1'b0);
      chk({tag, "_idle_valid"}, noise_valid, 1'b0);
    end else begin
      chk({tag, "_b2b_en"}, urng_en, 1'b1);
    end
  endtask

  task automatic pulse_start(input logic [15:0] sc);
    scale = sc;
    start = 1'b1;
    tick();
    start = 1'b0;
    scale = 16'($urandom);
  endtask

  initial begin
    logic [15:0] scs [9];
    int seen;

    // Reset state
    tick();
    tick();
    chk("rst_urng_en", urng_en, 1'b0);
    chk("rst_noise_valid", noise_valid, 1'b0);
    chk("rst_noise_out", noise_out, 16'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_proto_err", proto_err, 1'b0);
    rst = 1'b0;
    tick();

    // Mid-scale words give exactly zero; single-cycle start pulse.
    fixed_mode = 1'b1;
    fixed_word = 64'h8000_8000_8000_8000;
    pulse_start(16'hFFFF);
    chk("zero_busy", busy, 1'b1);
    finish_sample("zero", 16'hFFFF, 0, 1'b0, 16'h0);
    chk("zero_literal", last_out, 16'h0000);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (urng_en === 1'b1 || busy === 1'b1) seen++;
    end
    chk("pulse_stays_idle", seen, 0);

    // Full-scale positive words: wrap or saturate.
    fixed_word = 64'hFFFF_FFFF_FFFF_FFFF;
    pulse_start(16'h8000);
    finish_sample("max", 16'h8000, 0, 1'b0, 16'h0);
    chk("max_literal", last_out, EXP_MAX);

    // Full-scale negative words.
    fixed_word = 64'h0;
    pulse_start(16'hFFFF);
    finish_sample("min", 16'hFFFF, 0, 1'b0, 16'h0);

    // Downstream stall for 10 cycles.
    fixed_mode = 1'b0;
    pulse_start(16'h4000);
    finish_sample("stall", 16'h4000, 10, 1'b0, 16'h0);

    // Random back-to-back samples with start held high.
    for (int i = 0; i < 9; i++) scs[i] = 16'($urandom);
    scale = scs[0];
    start = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      finish_sample($sformatf("rnd%0d", i), scs[i], $urandom_range(0, 3), (i < 7), scs[i+1]);
    end
    start = 1'b0;
    chk("rnd_proto_err", proto_err, 1'b0);

    // Asynchronous reset in the middle of FILL.
    pulse_start(16'h1234);
    tick();
    rst = 1'b1;
    #1;
    chk("arst_urng_en", urng_en, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_noise_valid", noise_valid, 1'b0);
    chk("arst_noise_out", noise_out, 16'h0);
    chk("arst_proto_err", proto_err, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    words_q.delete();
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (noise_valid === 1'b1 || busy === 1'b1) seen++;
    end
    chk("arst_no_valid", seen, 0);

    // Unrequested word in IDLE sets the sticky error.
    chk("spur_before", proto_err, 1'b0);
    auto_urng = 1'b0;
    urng_valid = 1'b1;
    urng_data = {$urandom, $urandom};
    tick();
    urng_valid = 1'b0;
    auto_urng = 1'b1;
    chk("spur_set", proto_err, 1'b1);
    pulse_start(16'hA5A5);
    finish_sample("after_spur", 16'hA5A5, 1, 1'b0, 16'h0);
    chk("spur_sticky", proto_err, 1'b1);
    rst = 1'b1;
    #1;
    chk("spur_cleared_by_rst", proto_err, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clt_noise_gen.md
CLT_NOISE_GEN -- requirements
Module: clt_noise_gen

Interface
- REQ-001: Parameter WORDS, default 2, number of 64-bit URNG words summed per noise sample (legal range 1..8).
- REQ-002: Parameter OUT_W, default 16, width of the signed noise output.
- REQ-003: clk  input  1  single clock; all state on rising edge.
- REQ-004: rst  input  1  asynchronous, active-high reset.
- REQ-005: start  input  1  level enable; while high, samples are generated back-to-back.
- REQ-006: scale  input  16  unsigned sigma multiplier, Q0.16; sampled when a sample's accumulation begins.
- REQ-007: urng_en  output  1  request to upstream 64-bit URNG; one word per asserted cycle.
- REQ-008: urng_valid  input  1  upstream word valid; arrives exactly one cycle after the matching urng_en.
- REQ-009: urng_data  input  64  upstream uniform word.
- REQ-010: noise_valid  output  1  noise sample valid.
- REQ-011: noise_ready  input  1  downstream accept.
- REQ-012: noise_out  output  OUT_W  signed noise sample.
- REQ-013: busy  output  1  high in any state other than IDLE.
- REQ-014: proto_err  output  1  sticky; set on urng_valid not matching an outstanding request.

Function
- REQ-015: FSM states are IDLE, FILL, SCALE, OUT.
- REQ-016: IDLE -> FILL when start=1; scale is latched, the accumulator is cleared, and the issue/receive counters are cleared.
- REQ-017: FILL asserts urng_en for exactly WORDS consecutive cycles, counted by the issue counter.
- REQ-018: Each urng_valid word is split into four 16-bit lanes u; each lane contributes the signed term {~u[15],u[14:0]}, i.e. u-32768.
- REQ-019: The accumulator is signed, width 16+clog2(4*WORDS)+1, and adds all four lanes in one cycle.
- REQ-020: FILL -> SCALE when the receive counter reaches WORDS.
- REQ-021: SCALE registers product = acc * signed({1'b0,scale}), followed by an arithmetic shift right by 16; FSM -> OUT next cycle.
- REQ-022: OUT drives noise_valid=1 with noise_out stable until noise_ready=1.
- REQ-023: On handshake in OUT: if start=1, go to FILL as from IDLE (re-latch scale, clear); if start=0, go to IDLE.
- REQ-024: Latency from the first urng_en to noise_valid is WORDS+2 cycles.
- REQ-025: start deasserted during FILL/SCALE/OUT does not abort; the current sample completes and is delivered.
- REQ-026: urng_valid received in IDLE/SCALE/OUT, or beyond WORDS words in FILL, sets proto_err and the word is discarded; proto_err clears only on reset.
- REQ-027: noise_valid=1 with noise_ready=0 holds indefinitely with no new urng_en.

Reset
- REQ-028: On rst=1, asynchronously: state=IDLE, urng_en=0, noise_valid=0, noise_out=0, busy=0, proto_err=0, counters and accumulator=0.
- REQ-029: rst asserted mid-sample discards the partial sum; an in-flight upstream word arriving after release in IDLE sets proto_err.

Configuration
- REQ-030: Macro CLT_NOISE_SAT_EN: when defined, the scaled result saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; when undefined, it is truncated to the low OUT_W bits (two's-complement wrap).

Structure
- REQ-031: Package noise_pkg holds the FSM state enum, the lane width constant (16), and the function computing the accumulator width from WORDS.
- REQ-032: One sub-module, clt_lane_sum: combinational sum of four signed 16-bit lane terms to an 18-bit result.

Verification
- REQ-033: WORDS=1, scale=16'hFFFF, urng_data=64'h8000_8000_8000_8000 -> noise_out=0, noise_valid 3 cycles after urng_en.
- REQ-034: WORDS=2, scale=16'h8000, all words 64'hFFFF_FFFF_FFFF_FFFF -> acc=8*32767=262136, noise_out=131068; saturates to 32767 with CLT_NOISE_SAT_EN, wraps to 16'hFFFC without it.
- REQ-035: noise_ready held low 10 cycles in OUT -> noise_out stable, urng_en=0 throughout; accepted on the first high cycle.
- REQ-036: start pulsed one cycle -> exactly one sample produced, then IDLE with busy=0.
- REQ-037: Spurious urng_valid in IDLE -> proto_err=1 and remains set until rst.
- REQ-038: rst asserted during FILL -> all outputs 0 immediately (asynchronous), no noise_valid afterwards until start.
